ps2_rx: RTL

//  PS/2 keyboard receiver. Samples the PS/2 clock/data lines, deframes 11-bit device->host frames,
//  and collapses the E0/F0 prefixes into a single key event on kstb/make/code. Its outputs drive
//  the keyboard-matrix inputs kstb/make/code of the 56 MHz Spectrum core.

---
 rtl/ps2_rx.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: synchronise and filter the lines, deframe 11-bit frames and fold the
// E0/F0/E1 prefixes into single key events. Optional parity check when PS2_PARITY_EN is defined.
module ps2_rx #(
  parameter int unsigned FILTER  = 8,
  parameter int unsigned TIMEOUT = 5600
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2ck,
  input  logic       ps2d,
  output logic       kstb,
  output logic       make,
  output logic [7:0] code,
  output logic       ext
);

  localparam int unsigned FW = $clog2(FILTER + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  state_e state_q, state_d;

  // Index 0 = ps2ck, index 1 = ps2d.
  logic [1:0]    raw, sync1_q, sync2_q, flt_q, acc;
  logic [FW-1:0] cnt_q [2];
  logic          fall, din;

  logic [7:0]    shreg_q;
  logic [2:0]    bitcnt_q;
  logic [TW-1:0] timer_q;
  logic          timeout;
  logic          shift_en, frame_ok;
  logic          done_q;

  logic          kstb_q, make_q, ext_q, extf_q, brkf_q;
  logic [7:0]    code_q;
  logic [2:0]    pausec_q;
  logic          par_bad;

  assign raw = {ps2d, ps2ck};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      acc[i] = (sync2_q[i] != flt_q[i]) && (cnt_q[i] == FW'(FILTER - 1));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      flt_q   <= 2'b11;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] != flt_q[i]) begin
          if (acc[i]) begin
            flt_q[i] <= sync2_q[i];
            cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  assign fall    = acc[0] & flt_q[0];
  assign din     = flt_q[1];
  assign timeout = (state_q != StIdle) && (timer_q == TW'(TIMEOUT));

  // FSM: state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM: next state; a stop-bit fall beats a coincident timeout
  always_comb begin
    state_d = state_q;
    if (fall) begin
      unique case (state_q)
        StIdle:   if (!din) state_d = StData;
        StData:   if (bitcnt_q == 3'd7) state_d = StParity;
        StParity: state_d = StStop;
        StStop:   state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end else if (timeout) begin
      state_d = StIdle;
    end
  end

  // FSM: outputs
  always_comb begin
    shift_en = fall && (state_q == StData);
    frame_ok = fall && (state_q == StStop) && din;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shreg_q  <= '0;
      bitcnt_q <= '0;
      timer_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= frame_ok;
      if (state_q == StIdle)  bitcnt_q <= '0;
      else if (shift_en)      bitcnt_q <= bitcnt_q + 1'b1;
      if (shift_en)           shreg_q  <= {din, shreg_q[7:1]};
      if (fall || state_q == StIdle) timer_q <= '0;
      else if (!timeout)             timer_q <= timer_q + 1'b1;
    end
  end

`ifdef PS2_PARITY_EN
  logic par_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                             par_q <= 1'b0;
    else if (fall && state_q == StParity)   par_q <= din;
  end
  assign par_bad = ~^{shreg_q, par_q};
`else
  assign par_bad = 1'b0;
`endif

  // Completed-byte decode, one clock after the stop-bit fall
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      kstb_q   <= 1'b0;
      make_q   <= 1'b1;
      code_q   <= 8'h00;
      ext_q    <= 1'b0;
      extf_q   <= 1'b0;
      brkf_q   <= 1'b0;
      pausec_q <= '0;
    end else begin
      kstb_q <= 1'b0;
      if (done_q) begin
        if (par_bad) begin
          extf_q   <= 1'b0;
          brkf_q   <= 1'b0;
          pausec_q <= '0;
        end else if (pausec_q != 3'd0) begin
          pausec_q <= pausec_q - 1'b1;
        end else if (shreg_q == 8'hE0) begin
          extf_q <= 1'b1;
        end else if (shreg_q == 8'hF0) begin
          brkf_q <= 1'b1;
        end else if (shreg_q == 8'hE1) begin
          pausec_q <= 3'd7;
        end else if (!extf_q && !brkf_q &&
                     (shreg_q inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF})) begin
          kstb_q <= 1'b0;
        end else begin
          kstb_q <= 1'b1;
          code_q <= shreg_q;
          make_q <= ~brkf_q;
          ext_q  <= extf_q;
          extf_q <= 1'b0;
          brkf_q <= 1'b0;
        end
      end
    end
  end

  assign kstb = kstb_q;
  assign make = make_q;
  assign code = code_q;
  assign ext  = ext_q;

endmodule
